issue_queue: RTL
================

Name: issue_queue

Overview:
- Parametrised successor to the single-slot issue stage.
- Buffers decoded instructions from ID in a DEPTH-entry circular FIFO. Dispatches the head entry to ROB, RS or SLB, plus the rename table, only when every target has room.
- Sits between ID and ROB/RS/SLB/regfile. Exerts backpressure on ID with IQ_full. Flushed by jump_rst on mispredict.

Parameters:
DEPTH, 8, FIFO entries; power of two, >=2
DEPTH_LOG, 3, log2(DEPTH)
ROB_SIZE_LOG, 4, ROB index width
OP_SIZE_LOG, 6, opcode width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rdy  in  1  global clock enable; low freezes all state
jump_rst  in  1  mispredict flush
ID_valid  in  1  decoded instruction present
op  in  OP_SIZE_LOG  opcode
rs1, rs2, rd  in  5 each  register indices
imm  in  32  immediate
IF_pred_result  in  1  branch prediction
IF_curPC  in  32  instruction PC
ROB_full, RS_full, SLB_full  in  1 each  target has no free slot
ROB_tail  in  ROB_SIZE_LOG  next ROB index
IQ_full  out  1  count==DEPTH
IQ_count  out  DEPTH_LOG+1  occupancy
issue_rs1, issue_rs2  out  5  head sources, to regfile lookup
issue_op, issue_reg, issue_imm, issue_curPC, issue_pred  out  head fields
issue_reorder  out  ROB_SIZE_LOG  =ROB_tail
rename_send  out  1  write rename table
rename_reg  out  5  head rd
rename_reorder  out  ROB_SIZE_LOG  =ROB_tail
ROB_send, RS_send, SLB_send  out  1 each  dispatch strobes

Behaviour:
- Reset (async, rst=1): head=tail=count=0. Entry storage is not cleared. IQ_full=0, IQ_count=0, all send strobes 0.
- Head field outputs are driven from the head entry at all times. They are don't-care when count==0.
- enq = rdy & !jump_rst & ID_valid & (count<DEPTH).
  - A full queue never accepts, even if the head dispatches in the same cycle.
  - ID must hold the instruction while IQ_full=1.
- deq = rdy & !jump_rst & (count>0) & !ROB_full & !(is_mem ? SLB_full : RS_full).
- Strobes (combinational, gated by deq):
  - ROB_send=deq.
  - SLB_send=deq & is_mem.
  - RS_send=deq & !is_mem.
  - rename_send=deq & !is_branch & !is_store & (rd!=0).
- Class ranges: is_mem when op is in [LB..SW]; is_store when op is in [SB..SW]; is_branch when op is in [BEQ..BGEU]. Ranges use the shared opcode constants.
- Latency: an entry enqueued at edge N can first dispatch in the cycle after edge N. There is no ID-to-output bypass.
- Clock edge:
  - enq writes tail and tail++.
  - deq advances head++.
  - count += enq - deq.
  - Simultaneous enq+deq leaves count unchanged.
- Pointers wrap modulo DEPTH (natural DEPTH_LOG-bit overflow).
- jump_rst=1 (with rdy): all strobes forced 0 that cycle. At the edge, head=tail=count=0 and the ID_valid input is discarded.
- rdy=0: no state change and all strobes 0. rdy=0 takes priority over jump_rst; a flush is only taken while rdy=1.
- Stall: a blocked head also blocks every younger entry; dispatch is strictly in order. Head fields are held stable.

Decomposition:
- Opcode constants and class ranges (LB..SW, SB..SW, BEQ..BGEU), ROB_SIZE_LOG and OP_SIZE_LOG stay in the shared config include.
- Add a small combinational sub-module issue_classify (op, rd -> is_mem, is_store, is_branch, needs_rename). It is reused later by the ROB commit logic.

Test Plan:
- Reset, then 3 ALU ops ADD x1/x2/x3, no targets full: ADD x1 dispatches in the cycle after its enqueue edge. Over 3 consecutive cycles RS_send=ROB_send=rename_send=1 and rename_reg = 1, 2, 3 in order. count returns to 0.
- Hold ROB_full=1 and push 8 instructions: IQ_full=1 and IQ_count=8. A 9th ID_valid is not accepted. Drop ROB_full: in-order drain, 8 ROB_send pulses.
- Mix SW x5 (rd field 0) then LW x6: SW gives SLB_send=1 and rename_send=0. LW gives SLB_send=1, rename_send=1, rename_reg=6. Hold SLB_full=1 while an ADD is queued behind: the ADD must not pass.
- BEQ then ADD x0: BEQ gives RS_send=1 with rename_send=0. ADD x0 gives RS_send=1 with rename_send=0.
- Fill 5 entries, pulse jump_rst with ID_valid=1: strobes 0 that cycle, then count=0 and the incoming instruction is dropped. Enqueue 10 more across the wrap boundary: all 10 dispatch in order.
- rdy=0 for 3 cycles mid-stream with ID_valid=1: count, pointers and strobes frozen. Assert rst asynchronously mid-drain: outputs go 0 immediately without waiting for clk.

Source files
------------

// File: rtl/issue_queue_pkg.sv
// Shared issue-stage configuration: opcode encoding, class ranges and the queue entry layout.
// Classification relies on LB..SW, SB..SW and BEQ..BGEU each being contiguous.
package issue_queue_pkg;

    localparam int ROB_SIZE_LOG = 4;
    localparam int OP_SIZE_LOG  = 6;

    typedef logic [OP_SIZE_LOG-1:0] opcode_t;

    localparam opcode_t OP_NOP   = 6'd0;
    localparam opcode_t OP_LUI   = 6'd1;
    localparam opcode_t OP_AUIPC = 6'd2;
    localparam opcode_t OP_JAL   = 6'd3;
    localparam opcode_t OP_JALR  = 6'd4;
    localparam opcode_t OP_BEQ   = 6'd5;
    localparam opcode_t OP_BNE   = 6'd6;
    localparam opcode_t OP_BLT   = 6'd7;
    localparam opcode_t OP_BGE   = 6'd8;
    localparam opcode_t OP_BLTU  = 6'd9;
    localparam opcode_t OP_BGEU  = 6'd10;
    localparam opcode_t OP_LB    = 6'd11;
    localparam opcode_t OP_LH    = 6'd12;
    localparam opcode_t OP_LW    = 6'd13;
    localparam opcode_t OP_LBU   = 6'd14;
    localparam opcode_t OP_LHU   = 6'd15;
    localparam opcode_t OP_SB    = 6'd16;
    localparam opcode_t OP_SH    = 6'd17;
    localparam opcode_t OP_SW    = 6'd18;
    localparam opcode_t OP_ADDI  = 6'd19;
    localparam opcode_t OP_ADD   = 6'd28;

    localparam opcode_t MEM_FIRST    = OP_LB;
    localparam opcode_t MEM_LAST     = OP_SW;
    localparam opcode_t STORE_FIRST  = OP_SB;
    localparam opcode_t STORE_LAST   = OP_SW;
    localparam opcode_t BRANCH_FIRST = OP_BEQ;
    localparam opcode_t BRANCH_LAST  = OP_BGEU;

    function automatic logic op_in_range(opcode_t op, opcode_t lo, opcode_t hi);
        return (op >= lo) && (op <= hi);
    endfunction

    typedef struct packed {
        opcode_t     op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        pred;
        logic [31:0] pc;
    } iq_entry_t;

endpackage

// File: rtl/issue_classify.sv
// Opcode class decode shared by dispatch and ROB commit: memory/store/branch and
// whether the instruction writes a renamed destination.
module issue_classify
    import issue_queue_pkg::*;
(
    input  logic [OP_SIZE_LOG-1:0] op,
    input  logic [4:0]             rd,
    output logic                   is_mem,
    output logic                   is_store,
    output logic                   is_branch,
    output logic                   needs_rename
);

    assign is_mem       = op_in_range(op, MEM_FIRST, MEM_LAST);
    assign is_store     = op_in_range(op, STORE_FIRST, STORE_LAST);
    assign is_branch    = op_in_range(op, BRANCH_FIRST, BRANCH_LAST);
    // x0 is hardwired, so it never gets a rename-table entry.
    assign needs_rename = !is_branch && !is_store && (rd != 5'd0);

endmodule

// File: rtl/issue_queue.sv
// In-order issue queue: DEPTH-entry circular FIFO between ID and ROB/RS/SLB, dispatching
// the head entry only when the ROB and its execution target both have room.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int DEPTH_LOG = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    jump_rst,
    input  logic                    ID_valid,
    input  logic [OP_SIZE_LOG-1:0]  op,
    input  logic [4:0]              rs1,
    input  logic [4:0]              rs2,
    input  logic [4:0]              rd,
    input  logic [31:0]             imm,
    input  logic                    IF_pred_result,
    input  logic [31:0]             IF_curPC,
    input  logic                    ROB_full,
    input  logic                    RS_full,
    input  logic                    SLB_full,
    input  logic [ROB_SIZE_LOG-1:0] ROB_tail,
    output logic                    IQ_full,
    output logic [DEPTH_LOG:0]      IQ_count,
    output logic [4:0]              issue_rs1,
    output logic [4:0]              issue_rs2,
    output logic [OP_SIZE_LOG-1:0]  issue_op,
    output logic [4:0]              issue_reg,
    output logic [31:0]             issue_imm,
    output logic [31:0]             issue_curPC,
    output logic                    issue_pred,
    output logic [ROB_SIZE_LOG-1:0] issue_reorder,
    output logic                    rename_send,
    output logic [4:0]              rename_reg,
    output logic [ROB_SIZE_LOG-1:0] rename_reorder,
    output logic                    ROB_send,
    output logic                    RS_send,
    output logic                    SLB_send
);

    localparam logic [DEPTH_LOG:0]   FULL_CNT = (DEPTH_LOG+1)'(DEPTH);
    localparam logic [DEPTH_LOG:0]   CNT_ONE  = (DEPTH_LOG+1)'(1);
    localparam logic [DEPTH_LOG-1:0] PTR_ONE  = DEPTH_LOG'(1);

    iq_entry_t            mem_q [DEPTH];
    iq_entry_t            head_entry;
    iq_entry_t            wr_entry;
    logic [DEPTH_LOG-1:0] head_q, head_d;
    logic [DEPTH_LOG-1:0] tail_q, tail_d;
    logic [DEPTH_LOG:0]   count_q, count_d;
    logic                 enq, deq;
    logic                 is_mem, is_store, is_branch, needs_rename;
    logic                 unused_class;

    assign head_entry = mem_q[head_q];
    assign wr_entry   = '{op: op, rs1: rs1, rs2: rs2, rd: rd, imm: imm,
                          pred: IF_pred_result, pc: IF_curPC};

    issue_classify u_classify (
        .op           (head_entry.op),
        .rd           (head_entry.rd),
        .is_mem       (is_mem),
        .is_store     (is_store),
        .is_branch    (is_branch),
        .needs_rename (needs_rename)
    );

    // Store/branch qualification is already folded into needs_rename.
    assign unused_class = is_store | is_branch;

    // A full queue refuses ID even if the head leaves this cycle.
    assign enq = rdy && !jump_rst && ID_valid && (count_q < FULL_CNT);
    assign deq = rdy && !jump_rst && (count_q != '0) && !ROB_full
                 && !(is_mem ? SLB_full : RS_full);

    assign ROB_send    = deq;
    assign SLB_send    = deq && is_mem;
    assign RS_send     = deq && !is_mem;
    assign rename_send = deq && needs_rename;

    assign IQ_full  = (count_q == FULL_CNT);
    assign IQ_count = count_q;

    assign issue_rs1      = head_entry.rs1;
    assign issue_rs2      = head_entry.rs2;
    assign issue_op       = head_entry.op;
    assign issue_reg      = head_entry.rd;
    assign issue_imm      = head_entry.imm;
    assign issue_curPC    = head_entry.pc;
    assign issue_pred     = head_entry.pred;
    assign issue_reorder  = ROB_tail;
    assign rename_reg     = head_entry.rd;
    assign rename_reorder = ROB_tail;

    // NOTE: combinational blocks use blocking '=' with every output defaulted first,
    // so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rdy && jump_rst) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) tail_d = tail_q + PTR_ONE;
            if (deq) head_d = head_q + PTR_ONE;
            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: entry storage is deliberately not reset; count gates every read, so stale
    // contents are never observed and the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (enq) mem_q[tail_q] <= wr_entry;
    end

endmodule
